// File: rtl/ysyx_22040750_axi_wr_arbiter_pkg.sv
// Shared definitions for the AXI write arbiter and the 2-way round-robin arbiter.
package ysyx_22040750_axi_defs;

  // Arbiter FSM states: idle, or write port locked to channel 0 / channel 1.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  // Channel IDs, also the encoding of the round-robin priority register.
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  // AXI burst types.
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // AXI write response codes.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/ysyx_22040750_rr_arb2.sv
// Two-request round-robin arbiter. Grants are combinational from the requests and
// the priority register; priority flips only when a contested arbitration is taken.
module ysyx_22040750_rr_arb2
  import ysyx_22040750_axi_defs::*;
(
  input  logic clk,
  input  logic srst,
  input  logic req0,
  input  logic req1,
  input  logic advance,
  output logic grant0,
  output logic grant1
);

  logic prio_reg;

  // A lone request always wins; on a tie the priority register decides.
  assign grant0 = req0 & (~req1 | (prio_reg == CH0));
  assign grant1 = req1 & (~req0 | (prio_reg == CH1));

  // Hand priority to the loser whenever both competed and the grant was consumed.
  always_ff @(posedge clk) begin
    if (srst) begin
      prio_reg <= CH0;
    end else if (advance && req0 && req1) begin
      prio_reg <= ~prio_reg;
    end
  end

endmodule

// File: rtl/ysyx_22040750_axi_wr_arbiter.sv
// Shares one AXI4 write port between the D-cache writeback path (ch0) and the
// uncached/MMIO store path (ch1). A grant holds for AW + full W burst + B.
module ysyx_22040750_axi_wr_arbiter
  import ysyx_22040750_axi_defs::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                  I_clk,
  input  logic                  I_rst,
  // bus side
  output logic [ADDR_W-1:0]     O_axi_awaddr,
  output logic [7:0]            O_axi_awlen,
  output logic [2:0]            O_axi_awsize,
  output logic [1:0]            O_axi_awburst,
  output logic                  O_axi_awvalid,
  input  logic                  I_axi_awready,
  output logic [DATA_W-1:0]     O_axi_wdata,
  output logic [DATA_W/8-1:0]   O_axi_wstrb,
  output logic                  O_axi_wlast,
  output logic                  O_axi_wvalid,
  input  logic                  I_axi_wready,
  input  logic                  I_axi_bvalid,
  input  logic [1:0]            I_axi_bresp,
  output logic                  O_axi_bready,
  // master 0
  input  logic [ADDR_W-1:0]     I_ch0_awaddr,
  input  logic [7:0]            I_ch0_awlen,
  input  logic [2:0]            I_ch0_awsize,
  input  logic [1:0]            I_ch0_awburst,
  input  logic                  I_ch0_awvalid,
  output logic                  O_ch0_awready,
  input  logic [DATA_W-1:0]     I_ch0_wdata,
  input  logic [DATA_W/8-1:0]   I_ch0_wstrb,
  input  logic                  I_ch0_wlast,
  input  logic                  I_ch0_wvalid,
  output logic                  O_ch0_wready,
  output logic                  O_ch0_bvalid,
  output logic [1:0]            O_ch0_bresp,
  input  logic                  I_ch0_bready,
  // master 1
  input  logic [ADDR_W-1:0]     I_ch1_awaddr,
  input  logic [7:0]            I_ch1_awlen,
  input  logic [2:0]            I_ch1_awsize,
  input  logic [1:0]            I_ch1_awburst,
  input  logic                  I_ch1_awvalid,
  output logic                  O_ch1_awready,
  input  logic [DATA_W-1:0]     I_ch1_wdata,
  input  logic [DATA_W/8-1:0]   I_ch1_wstrb,
  input  logic                  I_ch1_wlast,
  input  logic                  I_ch1_wvalid,
  output logic                  O_ch1_wready,
  output logic                  O_ch1_bvalid,
  output logic [1:0]            O_ch1_bresp,
  input  logic                  I_ch1_bready
);

  arb_state_t state_reg;
  logic       aw_done_reg;
  logic       w_done_reg;
  logic       grant0;
  logic       grant1;
  logic       gnt0;
  logic       gnt1;
  logic       both_done;
  logic       aw_hs;
  logic       w_last_hs;
  logic       b_hs;

  // Only AW valid counts as a request; a W beat without AW never wins the port.
  ysyx_22040750_rr_arb2 u_arb (
    .clk     (I_clk),
    .srst    (I_rst),
    .req0    (I_ch0_awvalid),
    .req1    (I_ch1_awvalid),
    .advance (state_reg == IDLE),
    .grant0  (grant0),
    .grant1  (grant1)
  );

  // Reset forces every output low immediately, not just from the next cycle.
  assign gnt0      = (state_reg == GNT0) & ~I_rst;
  assign gnt1      = (state_reg == GNT1) & ~I_rst;
  assign both_done = aw_done_reg & w_done_reg;

  assign aw_hs     = O_axi_awvalid & I_axi_awready;
  assign w_last_hs = O_axi_wvalid & I_axi_wready & O_axi_wlast;
  assign b_hs      = I_axi_bvalid & O_axi_bready;

  // Pass-through of the granted channel; B is held off until AW and last W are both done.
  always_comb begin
    O_axi_awaddr  = '0;
    O_axi_awlen   = '0;
    O_axi_awsize  = '0;
    O_axi_awburst = '0;
    O_axi_awvalid = 1'b0;
    O_axi_wdata   = '0;
    O_axi_wstrb   = '0;
    O_axi_wlast   = 1'b0;
    O_axi_wvalid  = 1'b0;
    O_axi_bready  = 1'b0;
    O_ch0_awready = 1'b0;
    O_ch0_wready  = 1'b0;
    O_ch0_bvalid  = 1'b0;
    O_ch0_bresp   = '0;
    O_ch1_awready = 1'b0;
    O_ch1_wready  = 1'b0;
    O_ch1_bvalid  = 1'b0;
    O_ch1_bresp   = '0;
    if (gnt0) begin
      O_axi_awaddr  = I_ch0_awaddr;
      O_axi_awlen   = I_ch0_awlen;
      O_axi_awsize  = I_ch0_awsize;
      O_axi_awburst = I_ch0_awburst;
      O_axi_awvalid = I_ch0_awvalid & ~aw_done_reg;
      O_ch0_awready = I_axi_awready & ~aw_done_reg;
      O_axi_wdata   = I_ch0_wdata;
      O_axi_wstrb   = I_ch0_wstrb;
      O_axi_wlast   = I_ch0_wlast;
      O_axi_wvalid  = I_ch0_wvalid & ~w_done_reg;
      O_ch0_wready  = I_axi_wready & ~w_done_reg;
      O_axi_bready  = I_ch0_bready & both_done;
      O_ch0_bvalid  = I_axi_bvalid & both_done;
      O_ch0_bresp   = both_done ? I_axi_bresp : 2'b00;
    end else if (gnt1) begin
      O_axi_awaddr  = I_ch1_awaddr;
      O_axi_awlen   = I_ch1_awlen;
      O_axi_awsize  = I_ch1_awsize;
      O_axi_awburst = I_ch1_awburst;
      O_axi_awvalid = I_ch1_awvalid & ~aw_done_reg;
      O_ch1_awready = I_axi_awready & ~aw_done_reg;
      O_axi_wdata   = I_ch1_wdata;
      O_axi_wstrb   = I_ch1_wstrb;
      O_axi_wlast   = I_ch1_wlast;
      O_axi_wvalid  = I_ch1_wvalid & ~w_done_reg;
      O_ch1_wready  = I_axi_wready & ~w_done_reg;
      O_axi_bready  = I_ch1_bready & both_done;
      O_ch1_bvalid  = I_axi_bvalid & both_done;
      O_ch1_bresp   = both_done ? I_axi_bresp : 2'b00;
    end
  end

  // Grant FSM plus per-transaction progress flags; B handshake releases the port.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_reg   <= IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant0) begin
            state_reg <= GNT0;
          end else if (grant1) begin
            state_reg <= GNT1;
          end
        end
        GNT0, GNT1: begin
          if (b_hs) begin
            state_reg   <= IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_done_reg <= 1'b1;
            end
            if (w_last_hs) begin
              w_done_reg <= 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040750_axi_wr_arbiter.sv
// Self-checking bench for the two-master AXI write arbiter.
module tb_ysyx_22040750_axi_wr_arbiter;
  import ysyx_22040750_axi_defs::*;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int STRB_W = DATA_W / 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire  [ADDR_W-1:0] axi_awaddr;
  wire  [7:0]        axi_awlen;
  wire  [2:0]        axi_awsize;
  wire  [1:0]        axi_awburst;
  wire               axi_awvalid;
  logic              axi_awready;
  wire  [DATA_W-1:0] axi_wdata;
  wire  [STRB_W-1:0] axi_wstrb;
  wire               axi_wlast;
  wire               axi_wvalid;
  logic              axi_wready;
  logic              axi_bvalid;
  logic [1:0]        axi_bresp;
  wire               axi_bready;

  logic [1:0][ADDR_W-1:0] ch_awaddr;
  logic [1:0][7:0]        ch_awlen;
  logic [1:0][2:0]        ch_awsize;
  logic [1:0][1:0]        ch_awburst;
  logic [1:0]             ch_awvalid;
  wire  [1:0]             ch_awready;
  logic [1:0][DATA_W-1:0] ch_wdata;
  logic [1:0][STRB_W-1:0] ch_wstrb;
  logic [1:0]             ch_wlast;
  logic [1:0]             ch_wvalid;
  wire  [1:0]             ch_wready;
  wire  [1:0]             ch_bvalid;
  wire  [1:0][1:0]        ch_bresp;
  logic [1:0]             ch_bready;

  ysyx_22040750_axi_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .I_clk(clk), .I_rst(rst),
    .O_axi_awaddr(axi_awaddr), .O_axi_awlen(axi_awlen), .O_axi_awsize(axi_awsize),
    .O_axi_awburst(axi_awburst), .O_axi_awvalid(axi_awvalid), .I_axi_awready(axi_awready),
    .O_axi_wdata(axi_wdata), .O_axi_wstrb(axi_wstrb), .O_axi_wlast(axi_wlast),
    .O_axi_wvalid(axi_wvalid), .I_axi_wready(axi_wready),
    .I_axi_bvalid(axi_bvalid), .I_axi_bresp(axi_bresp), .O_axi_bready(axi_bready),
    .I_ch0_awaddr(ch_awaddr[0]), .I_ch0_awlen(ch_awlen[0]), .I_ch0_awsize(ch_awsize[0]),
    .I_ch0_awburst(ch_awburst[0]), .I_ch0_awvalid(ch_awvalid[0]), .O_ch0_awready(ch_awready[0]),
    .I_ch0_wdata(ch_wdata[0]), .I_ch0_wstrb(ch_wstrb[0]), .I_ch0_wlast(ch_wlast[0]),
    .I_ch0_wvalid(ch_wvalid[0]), .O_ch0_wready(ch_wready[0]),
    .O_ch0_bvalid(ch_bvalid[0]), .O_ch0_bresp(ch_bresp[0]), .I_ch0_bready(ch_bready[0]),
    .I_ch1_awaddr(ch_awaddr[1]), .I_ch1_awlen(ch_awlen[1]), .I_ch1_awsize(ch_awsize[1]),
    .I_ch1_awburst(ch_awburst[1]), .I_ch1_awvalid(ch_awvalid[1]), .O_ch1_awready(ch_awready[1]),
    .I_ch1_wdata(ch_wdata[1]), .I_ch1_wstrb(ch_wstrb[1]), .I_ch1_wlast(ch_wlast[1]),
    .I_ch1_wvalid(ch_wvalid[1]), .O_ch1_wready(ch_wready[1]),
    .O_ch1_bvalid(ch_bvalid[1]), .O_ch1_bresp(ch_bresp[1]), .I_ch1_bready(ch_bready[1])
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Bus-side handshake counters.
  int w_hs_cnt = 0;
  int b_hs_cnt = 0;
  always @(posedge clk) begin
    if (axi_wvalid && axi_wready) w_hs_cnt <= w_hs_cnt + 1;
    if (axi_bvalid && axi_bready) b_hs_cnt <= b_hs_cnt + 1;
  end

  // Scoreboards: expectations queued when a master drives stimulus.
  typedef struct { logic [ADDR_W-1:0] addr; logic [7:0] len; } aw_exp_t;
  aw_exp_t           aw_q[$];
  logic [DATA_W-1:0] w_q[$];
  logic [1:0]        b_q[$];

  typedef struct { logic ch; logic [ADDR_W-1:0] addr; logic [7:0] len; logic [1:0] resp; } vec_t;
  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: act=%0h req=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input logic ch, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
    ch_awaddr[ch]  = addr;
    ch_awlen[ch]   = len;
    ch_awsize[ch]  = 3'd3;
    ch_awburst[ch] = BURST_INCR;
    ch_awvalid[ch] = 1'b1;
    aw_q.push_back('{addr, len});
  endtask

  task automatic expect_grant(input logic ch, input string tag);
    aw_exp_t e;
    #1;
    chk({tag, "_state"}, 64'(dut.state_reg), 64'(ch ? GNT1 : GNT0));
    chk({tag, "_awvalid"}, 64'(axi_awvalid), 1);
    chk({tag, "_awsize"}, 64'(axi_awsize), 3);
    chk({tag, "_awburst"}, 64'(axi_awburst), 64'(BURST_INCR));
    if (aw_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_sb: act=grant req=no_pending_entry", tag);
    end else begin
      e = aw_q.pop_front();
      chk({tag, "_awaddr"}, 64'(axi_awaddr), 64'(e.addr));
      chk({tag, "_awlen"}, 64'(axi_awlen), 64'(e.len));
    end
  endtask

  task automatic do_aw(input logic ch);
    axi_awready = 1'b1;
    #1;
    chk("aw_ready_fwd", 64'(ch_awready[ch]), 1);
    chk("aw_other_ready", 64'(ch_awready[~ch]), 0);
    tick();
    ch_awvalid[ch] = 1'b0;
    axi_awready    = 1'b0;
  endtask

  task automatic do_w(input logic ch, input int beats, input int total, input logic [ADDR_W-1:0] addr);
    for (int b = 0; b < beats; b++) begin
      ch_wdata[ch]  = {addr, 32'(b)} ^ 64'hA5A5_5A5A_0F0F_F0F0;
      ch_wstrb[ch]  = 8'hFF ^ 8'(b);
      ch_wlast[ch]  = (b == total - 1);
      ch_wvalid[ch] = 1'b1;
      axi_wready    = 1'b1;
      w_q.push_back(ch_wdata[ch]);
      #1;
      chk("w_valid", 64'(axi_wvalid), 1);
      chk("w_ready_fwd", 64'(ch_wready[ch]), 1);
      chk("w_other_ready", 64'(ch_wready[~ch]), 0);
      chk("w_data", 64'(axi_wdata), 64'(w_q.pop_front()));
      chk("w_strb", 64'(axi_wstrb), 64'(8'hFF ^ 8'(b)));
      chk("w_last", 64'(axi_wlast), 64'(b == total - 1));
      tick();
    end
    ch_wvalid[ch] = 1'b0;
    ch_wlast[ch]  = 1'b0;
    axi_wready    = 1'b0;
  endtask

  task automatic do_b(input logic ch, input logic [1:0] resp);
    axi_bvalid    = 1'b1;
    axi_bresp     = resp;
    ch_bready[ch] = 1'b1;
    b_q.push_back(resp);
    #1;
    chk("b_ready", 64'(axi_bready), 1);
    chk("b_valid_fwd", 64'(ch_bvalid[ch]), 1);
    chk("b_resp", 64'(ch_bresp[ch]), 64'(b_q.pop_front()));
    chk("b_other_valid", 64'(ch_bvalid[~ch]), 0);
    tick();
    axi_bvalid    = 1'b0;
    axi_bresp     = 2'b00;
    ch_bready[ch] = 1'b0;
    #1;
    chk("idle_after_b", 64'(dut.state_reg), 64'(IDLE));
    chk("bubble_awvalid", 64'(axi_awvalid), 0);
    $display("txn ch%0d resp=%0d complete at %0t", ch, resp, $time);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, 64'(dut.state_reg), 64'(IDLE));
    chk({tag, "_awvalid"}, 64'(axi_awvalid), 0);
    chk({tag, "_awaddr"}, 64'(axi_awaddr), 0);
    chk({tag, "_wvalid"}, 64'(axi_wvalid), 0);
    chk({tag, "_wdata"}, 64'(axi_wdata), 0);
    chk({tag, "_bready"}, 64'(axi_bready), 0);
    chk({tag, "_ch_awready"}, 64'(ch_awready), 0);
    chk({tag, "_ch_wready"}, 64'(ch_wready), 0);
    chk({tag, "_ch_bvalid"}, 64'(ch_bvalid), 0);
    chk({tag, "_ch_bresp"}, 64'(ch_bresp), 0);
  endtask

  initial begin
    int w0;
    int b0;
    vecs[0] = '{1'b0, 32'h8000_0000, 8'd3, RESP_OKAY};
    vecs[1] = '{1'b1, 32'h1000_0040, 8'd0, RESP_SLVERR};
    vecs[2] = '{1'b0, 32'h8000_0100, 8'd1, RESP_DECERR};
    vecs[3] = '{1'b1, 32'h1000_0080, 8'd2, RESP_EXOKAY};

    rst = 1'b1;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    ch_awaddr = '0; ch_awlen = '0; ch_awsize = '0; ch_awburst = '0; ch_awvalid = '0;
    ch_wdata = '0; ch_wstrb = '0; ch_wlast = '0; ch_wvalid = '0; ch_bready = '0;
    tick();
    tick();
    // Activity on every input while reset is held: outputs must stay zero.
    ch_awvalid = 2'b11; ch_wvalid = 2'b11; ch_bready = 2'b11; ch_awaddr[0] = 32'hDEAD_0000;
    axi_awready = 1; axi_wready = 1; axi_bvalid = 1; axi_bresp = RESP_SLVERR;
    tick();
    check_all_zero("reset");
    chk("reset_prio", 64'(dut.u_arb.prio_reg), 64'(CH0));
    ch_awvalid = '0; ch_wvalid = '0; ch_bready = '0; ch_awaddr = '0;
    axi_awready = 0; axi_wready = 0; axi_bvalid = 0; axi_bresp = 0;
    rst = 1'b0;
    tick();
    check_all_zero("idle");

    // Table: single-master transactions, AW accepted before the W burst.
    for (int i = 0; i < 4; i++) begin
      request(vecs[i].ch, vecs[i].addr, vecs[i].len);
      tick();
      expect_grant(vecs[i].ch, "vec");
      do_aw(vecs[i].ch);
      w0 = w_hs_cnt;
      do_w(vecs[i].ch, int'(vecs[i].len) + 1, int'(vecs[i].len) + 1, vecs[i].addr);
      chk("vec_w_handshakes", 64'(w_hs_cnt - w0), 64'(int'(vecs[i].len) + 1));
      do_b(vecs[i].ch, vecs[i].resp);
    end

    // Both request in the same cycle; ch1 also pushes W while locked out.
    request(1'b0, 32'h8000_0200, 8'd0);
    request(1'b1, 32'h8000_1000, 8'd0);
    ch_wvalid[1] = 1'b1; ch_wlast[1] = 1'b1; ch_wdata[1] = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    expect_grant(1'b0, "tie_ch0");
    chk("tie_prio_after_ch0", 64'(dut.u_arb.prio_reg), 64'(CH1));
    do_aw(1'b0);
    do_w(1'b0, 1, 1, 32'h8000_0200);
    do_b(1'b0, RESP_OKAY);
    // ch0 re-requests in the bubble cycle; priority now favours ch1.
    request(1'b0, 32'h8000_0300, 8'd1);
    tick();
    expect_grant(1'b1, "rr_ch1");
    chk("rr_prio_after_ch1", 64'(dut.u_arb.prio_reg), 64'(CH0));
    do_aw(1'b1);
    do_w(1'b1, 1, 1, 32'h8000_1000);
    do_b(1'b1, RESP_OKAY);
    tick();
    expect_grant(1'b0, "rr_ch0_again");
    do_aw(1'b0);
    do_w(1'b0, 2, 2, 32'h8000_0300);
    do_b(1'b0, RESP_OKAY);

    // ch1: W completes two cycles before AW, with bvalid stuck high from the start.
    request(1'b1, 32'h1000_0100, 8'd0);
    tick();
    expect_grant(1'b1, "early_b");
    axi_bvalid = 1; axi_bresp = RESP_OKAY; ch_bready[1] = 1;
    ch_wdata[1] = 64'h1234_5678_9ABC_DEF0; ch_wstrb[1] = 8'hFF; ch_wlast[1] = 1; ch_wvalid[1] = 1;
    axi_wready = 1;
    #1;
    chk("early_b_wready", 64'(ch_wready[1]), 1);
    chk("early_b_hold_bready0", 64'(axi_bready), 0);
    chk("early_b_hold_bvalid0", 64'(ch_bvalid[1]), 0);
    b0 = b_hs_cnt;
    tick();
    ch_wvalid[1] = 0; ch_wlast[1] = 0; axi_wready = 0;
    #1;
    chk("early_b_hold_bready1", 64'(axi_bready), 0);
    tick();
    axi_awready = 1;
    #1;
    chk("early_b_awready", 64'(ch_awready[1]), 1);
    chk("early_b_hold_bready2", 64'(axi_bready), 0);
    tick();
    ch_awvalid[1] = 0; axi_awready = 0;
    #1;
    chk("early_b_bready", 64'(axi_bready), 1);
    chk("early_b_bvalid", 64'(ch_bvalid[1]), 1);
    tick();
    #1;
    chk("early_b_idle", 64'(dut.state_reg), 64'(IDLE));
    chk("early_b_no_second", 64'(axi_bready), 0);
    tick();
    chk("early_b_b_count", 64'(b_hs_cnt - b0), 1);
    axi_bvalid = 0; ch_bready[1] = 0;
    $display("txn ch1 early-b sequence complete at %0t", $time);

    // Reset after beat 2 of 4 while ch1 waits; ch1 then wins the idle port.
    request(1'b0, 32'h8000_4000, 8'd3);
    tick();
    expect_grant(1'b0, "mid_rst");
    do_aw(1'b0);
    request(1'b1, 32'h1000_0200, 8'd0);
    do_w(1'b0, 2, 4, 32'h8000_4000);
    rst = 1'b1;
    ch_wvalid[0] = 1; axi_wready = 1; axi_awready = 1;
    tick();
    check_all_zero("mid_rst");
    chk("mid_rst_aw_done", 64'(dut.aw_done_reg), 0);
    chk("mid_rst_w_done", 64'(dut.w_done_reg), 0);
    ch_wvalid[0] = 0; axi_wready = 0; axi_awready = 0;
    rst = 1'b0;
    tick();
    expect_grant(1'b1, "post_rst");
    do_aw(1'b1);
    do_w(1'b1, 1, 1, 32'h1000_0200);
    do_b(1'b1, RESP_OKAY);

    // Reset while priority points at ch1: after reset ch0 wins a tie again.
    request(1'b0, 32'h8000_5000, 8'd0);
    request(1'b1, 32'h1000_0300, 8'd0);
    tick();
    expect_grant(1'b0, "pre_rst2");
    chk("pre_rst2_prio", 64'(dut.u_arb.prio_reg), 64'(CH1));
    rst = 1'b1;
    tick();
    chk("rst2_prio", 64'(dut.u_arb.prio_reg), 64'(CH0));
    check_all_zero("rst2");
    rst = 1'b0;
    aw_q.delete();
    request(1'b0, 32'h8000_5000, 8'd0);
    request(1'b1, 32'h1000_0300, 8'd0);
    tick();
    expect_grant(1'b0, "rst2_ch0");
    do_aw(1'b0);
    do_w(1'b0, 1, 1, 32'h8000_5000);
    do_b(1'b0, RESP_OKAY);
    tick();
    expect_grant(1'b1, "rst2_ch1");
    chk("rst2_prio_ch1", 64'(dut.u_arb.prio_reg), 64'(CH1));
    do_aw(1'b1);
    do_w(1'b1, 1, 1, 32'h1000_0300);
    do_b(1'b1, RESP_SLVERR);

    chk("sb_aw_drained", 64'(aw_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
